sideband_fifo: RTL

- Re-associates per-event sideband data (e.g. x/y/timestamp) with results that leave a fixed- or variable-latency compute pipeline.
- Sideband is pushed when an event is launched into the pipeline; one entry is popped when the pipeline's result-valid fires.
- Output is registered, with one-cycle latency matching a single delay stage.
- Reports occupancy and sticky overflow/underflow errors.

---
 rtl/sideband_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sideband_fifo.sv
// -----------------------------------------------------------------------------
// sideband_fifo
//
// Purpose:
//   Re-associates per-event sideband words (x/y/timestamp, ...) with results
//   leaving a compute pipeline. A word is pushed when an event is launched and
//   one word is popped each time the pipeline's result-valid fires. The popped
//   word appears on a registered output one cycle after the pop, matching a
//   single delay stage on the result path.
//
// Parameters:
//   N      sideband word width in bits
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset (synchronous release expected)
//   push_valid  event launched; store push_data
//   push_data   sideband word to store
//   pop         pipeline result valid; read one entry
//   odata       registered sideband word of the popped entry
//   ovalid      odata valid, one-cycle pulse per accepted pop
//   full        count == DEPTH
//   empty       count == 0
//   count       occupancy, 0..DEPTH
//   overflow    sticky: a push was dropped because the FIFO was full
//   underflow   sticky: a pop arrived while the FIFO was empty
//
// Configuration:
//   SIDEBAND_FIFO_BYPASS_EN  when defined, a push and pop arriving together on
//                            an empty FIFO forward push_data straight to odata
//                            without touching storage, pointers or count.
// -----------------------------------------------------------------------------
module sideband_fifo #(
   parameter int N     = 4,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_valid,
   input  logic [N-1:0]             push_data,
   input  logic                     pop,
   output logic [N-1:0]             odata,
   output logic                     ovalid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = $clog2(DEPTH);

   // Storage is deliberately not reset; only the pointers define validity.
   logic [N-1:0]  mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [N-1:0]  odata_q, odata_d;
   logic          ovalid_q, ovalid_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic          pop_acc;
   logic          push_acc;
   logic          bypass;

   assign full      = (count_q == (PW+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign odata     = odata_q;
   assign ovalid    = ovalid_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   always_comb begin
      pop_acc = pop & ~empty;
`ifdef SIDEBAND_FIFO_BYPASS_EN
      bypass  = empty & push_valid & pop;
`else
      bypass  = 1'b0;
`endif
      // A simultaneous pop frees a slot, so a full FIFO can still take a push.
      push_acc = push_valid & (~full | pop_acc) & ~bypass;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      odata_d     = odata_q;
      ovalid_d    = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         odata_d  = mem_q[rd_ptr_q];
         ovalid_d = 1'b1;
      end else if (bypass) begin
         odata_d  = push_data;
         ovalid_d = 1'b1;
      end

      if (push_acc && !pop_acc) begin
         count_d = count_q + (PW+1)'(1);
      end else if (pop_acc && !push_acc) begin
         count_d = count_q - (PW+1)'(1);
      end

      if (push_valid && full && !pop_acc) begin
         overflow_d = 1'b1;
      end
      if (pop && empty && !bypass) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         odata_q     <= '0;
         ovalid_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         odata_q     <= odata_d;
         ovalid_q    <= ovalid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule
